// File: rtl/spy_target_pkg.sv
// spy_target_pkg: shared constants and types for the CADR spy-port target.
// Holds the spy register address map, the MODE register bit layout and the
// single-step FSM state encoding.
package spy_target_pkg;

    // Spy register addresses (eadr values)
    localparam logic [3:0] SPY_PC      = 4'd0;
    localparam logic [3:0] SPY_STATUS  = 4'd1;
    localparam logic [3:0] SPY_MODE    = 4'd2;
    localparam logic [3:0] SPY_STEPCNT = 4'd3;
    localparam logic [3:0] SPY_SCRATCH = 4'd4;
    localparam logic [3:0] SPY_ID      = 4'd5;
    localparam logic [3:0] SPY_TRACE   = 4'd6;

    // MODE register: bit 0 requests a CPU halt
    localparam int MODE_HALT_BIT = 0;

    // Single-step sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } step_state_e;

endpackage

// File: rtl/spy_trace_fifo.sv
// spy_trace_fifo: small PC trace buffer for the spy-port target.
// Overwrite-on-full: pushing into a full buffer drops the oldest entry so the
// buffer always holds the most recent DEPTH pushes. DEPTH must be a power of 2.
// Only instantiated when SPY_TARGET_TRACE_EN is defined.
module spy_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage array: written on push, contents are don't-care until counted valid
    // NOTE: the data array is not reset; occupancy is tracked by r_count, so
    // stale contents are never visible and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers and occupancy; a push into a full buffer also advances the read side
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop || (i_push && w_full)) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   if (!w_full) r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spy_port_target.sv
// spy_port_target: target end of the CADR spy debug bus.
// Decodes eadr, returns registered read data while dbread is high, commits one
// write per rising edge of dbwrite, and runs a halt/single-step sequencer.
// Optional feature: define SPY_TARGET_TRACE_EN to add an 8-entry PC trace
// FIFO at address 6 (otherwise address 6 and trace_count read 0).
module spy_port_target
    import spy_target_pkg::*;
#(
    parameter logic [15:0] ID_VALUE = 16'hCADD,
    parameter int          STEP_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  eadr,
    input  logic        dbread,
    input  logic        dbwrite,
    input  logic [15:0] spy_in,
    output logic [15:0] spy_out,
    input  logic [13:0] pc_in,
    input  logic [5:0]  state_in,
    input  logic        machrun,
    input  logic        fetch,
    output logic        halt,
    output logic        step
);

    logic              r_dbwrite_d;
    logic              r_halt;
    logic [15:0]       r_scratch;
    logic [STEP_W-1:0] r_stepcnt;
    logic [15:0]       r_spy_out;
    step_state_e       r_state;
    step_state_e       w_next_state;

    logic              w_wr_stb;
    logic              w_wr_mode;
    logic              w_wr_cnt;
    logic              w_halt_clr;
    logic              w_cnt_abort;
    logic              w_fetch_done;
    logic              w_step;
    logic              w_step_busy;
    logic [STEP_W-1:0] w_cnt_wdata;
    logic [15:0]       w_rd_data;
    logic [3:0]        w_trace_count;
    logic [15:0]       w_trace_data;

    // Write strobe fires once per dbwrite assertion, in the cycle it rises
    assign w_wr_stb     = dbwrite && !r_dbwrite_d;
    assign w_wr_mode    = w_wr_stb && (eadr == SPY_MODE);
    // Step counts are only accepted while the CPU is held
    assign w_wr_cnt     = w_wr_stb && (eadr == SPY_STEPCNT) && r_halt;
    assign w_cnt_wdata  = spy_in[STEP_W-1:0];
    assign w_halt_clr   = w_wr_mode && !spy_in[MODE_HALT_BIT];
    assign w_cnt_abort  = w_wr_cnt && (w_cnt_wdata == '0);
    assign w_fetch_done = (r_state == ST_WAIT) && fetch;
    assign w_step_busy  = (r_state != ST_IDLE);

    assign halt    = r_halt;
    assign step    = w_step;
    assign spy_out = r_spy_out;

    // Bus-side registers: write edge detect, MODE and SCRATCH
    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbwrite_d <= 1'b0;
            r_halt      <= 1'b0;
            r_scratch   <= '0;
        end else begin
            r_dbwrite_d <= dbwrite;
            if (w_wr_mode) begin
                r_halt <= spy_in[MODE_HALT_BIT];
            end
            if (w_wr_stb && (eadr == SPY_SCRATCH)) begin
                r_scratch <= spy_in;
            end
        end
    end

    // Remaining step count: loaded by the driver, decremented at each completed step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stepcnt <= '0;
        end else if (w_halt_clr) begin
            r_stepcnt <= '0;
        end else if (w_wr_cnt) begin
            // A new count landing on the completing fetch is charged for that step
            if (w_fetch_done && (w_cnt_wdata != '0)) begin
                r_stepcnt <= w_cnt_wdata - STEP_W'(1);
            end else begin
                r_stepcnt <= w_cnt_wdata;
            end
        end else if (w_fetch_done && (r_stepcnt != '0)) begin
            r_stepcnt <= r_stepcnt - STEP_W'(1);
        end
    end

    // Step sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Step sequencer next state and step pulse
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_halt && (r_stepcnt != '0)) begin
                    w_next_state = ST_PULSE;
                end
            end
            ST_PULSE: begin
                w_step       = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Releasing halt or writing a zero count abandons any stepping
        if (w_halt_clr || w_cnt_abort) begin
            w_next_state = ST_IDLE;
        end
    end

`ifdef SPY_TARGET_TRACE_EN
    logic        r_dbread_d;
    logic [15:0] r_trace_hold;
    logic [15:0] w_fifo_dout;
    logic        w_trace_pop;
    logic [15:0] w_trace_head;

    // Pop once at the start of a trace read; a combined read/write never pops
    assign w_trace_pop  = dbread && !r_dbread_d && !dbwrite && (eadr == SPY_TRACE);
    assign w_trace_head = (w_trace_count != 4'd0) ? w_fifo_dout : 16'h0000;
    assign w_trace_data = w_trace_pop ? w_trace_head : r_trace_hold;

    spy_trace_fifo #(
        .DEPTH (8),
        .W     (16)
    ) u_trace_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (fetch && machrun),
        .i_din   ({1'b1, 1'b0, pc_in}),
        .i_pop   (w_trace_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_trace_count)
    );

    // Hold the popped entry so it stays visible for the rest of the read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbread_d   <= 1'b0;
            r_trace_hold <= '0;
        end else begin
            r_dbread_d <= dbread;
            if (w_trace_pop) begin
                r_trace_hold <= w_trace_head;
            end
        end
    end
`else
    assign w_trace_count = 4'd0;
    assign w_trace_data  = 16'h0000;
`endif

    // Read data selection by spy address
    always_comb begin
        w_rd_data = '0;
        case (eadr)
            SPY_PC:      w_rd_data = {2'b00, pc_in};
            SPY_STATUS:  w_rd_data = {machrun, r_halt, w_step_busy, w_trace_count,
                                      3'b000, state_in};
            SPY_MODE:    w_rd_data[MODE_HALT_BIT] = r_halt;
            SPY_STEPCNT: w_rd_data = 16'(r_stepcnt);
            SPY_SCRATCH: w_rd_data = r_scratch;
            SPY_ID:      w_rd_data = ID_VALUE;
            SPY_TRACE:   w_rd_data = w_trace_data;
            default:     w_rd_data = '0;
        endcase
    end

    // Registered read port: zero unless a pure read is in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spy_out <= '0;
        end else if (dbread && !dbwrite) begin
            r_spy_out <= w_rd_data;
        end else begin
            r_spy_out <= '0;
        end
    end

endmodule

// File: doc/spy_port_target.md
# spy_port_target

Debug-bus responder for the CADR spy port: the target end of the eadr/dbread/dbwrite/spy handshake issued by the serial spy driver. It decodes the 4-bit spy address, returns register data on reads, and applies writes to a small control/status register file. Through that register file it halts the CPU, single-steps it a programmed number of instructions, and exposes PC and state snapshots. It sits beside `caddr` in the top level, on the CPU clock.

## Interface
- `ID_VALUE`, 16'hCADD: constant returned at address 5.
- `STEP_W`, 16: width of the step counter (≤16).
- `clk` in 1: CPU clock; all logic rises on it.
- `reset` in 1: asynchronous, active-low reset.
- `eadr` in 4: spy register address; synchronous to `clk`.
- `dbread` in 1: read request, level.
- `dbwrite` in 1: write request, level.
- `spy_in` in 16: write data from the driver.
- `spy_out` out 16: read data to the driver.
- `pc_in` in 14: current CPU PC.
- `state_in` in 6: CPU one-hot state.
- `machrun` in 1: CPU running.
- `fetch` in 1: one-cycle pulse at each instruction boundary.
- `halt` out 1: CPU halt request.
- `step` out 1: one-cycle single-step pulse.

## Operation
- Register map:
  - 0 PC (ro): {2'b0, pc_in}.
  - 1 STATUS (ro): {machrun, halt, step_busy, trace_count[3:0], 3'b0, state_in}.
  - 2 MODE (rw): bit0 = halt. Other bits read 0.
  - 3 STEPCNT (rw): reads the remaining step count.
  - 4 SCRATCH (rw).
  - 5 ID (ro).
  - 6 TRACE (ro, macro only).
  - 7–15: read 0; writes ignored.
- Write: committed on the rising edge of `dbwrite` (high now, low the previous cycle). Exactly one write per assertion; `spy_in` and `eadr` are sampled in that cycle.
- Read: `spy_out` is registered. While `dbread` is high, `spy_out` is loaded with `reg[eadr]` every cycle. While `dbread` is low, `spy_out` is 0.
- Simultaneous `dbread` and `dbwrite`: the write is performed and `spy_out` is 0.
- Step FSM states are IDLE, PULSE and WAIT.
  - IDLE → PULSE when stepcnt≠0 and halt=1.
  - PULSE: `step`=1 for one cycle, then → WAIT.
  - WAIT: when `fetch`=1, stepcnt decrements → IDLE.
- STEPCNT writes:
  - Accepted only while halt=1; otherwise ignored and the count stays 0.
  - Writing 0 aborts: count cleared, FSM → IDLE next cycle.
  - A nonzero write in PULSE or WAIT replaces the count; the in-flight step still completes and decrements the new value.
- Writing MODE.halt=0 while stepping clears stepcnt and returns the FSM to IDLE.
- `step_busy` = (FSM≠IDLE).

## Timing
- Reset: `spy_out`=0, `halt`=0, `step`=0, MODE=0, STEPCNT=0, SCRATCH=0, FSM=IDLE, trace empty.
- Read latency: data is valid on `spy_out` 1 cycle after `dbread` and `eadr` are sampled high. The driver samples ≥2 cycles after raising `dbread`.
- Write latency: the register is updated at the edge after the `dbwrite` rise. `halt` changes on that same edge.
- Step latency: first `step` pulse 1 cycle after STEPCNT is written with halt=1. Consecutive pulses are spaced by at least fetch latency + 2 cycles.
- A `fetch` pulse outside WAIT is ignored by the FSM.
- Reset asserted mid-operation clears everything immediately, including an in-flight `step`.

## Configuration
- `SPY_TARGET_TRACE_EN` defined:
  - Address 6 is an 8-entry PC trace FIFO.
  - Push {1'b1, 1'b0, pc_in} on each `fetch` while `machrun`=1.
  - When full, the oldest entry is overwritten.
  - Pop on the rising edge of `dbread` with `eadr`=6; the popped value is shown for the rest of that read.
  - A read while empty returns 0 and does not pop.
  - trace_count ranges 0–8.
- Not defined: address 6 reads 0, trace_count reads 0, and no FIFO logic exists.

## Structure
- Package `spy_target_pkg` holds:
  - address constants: SPY_PC, SPY_STATUS, SPY_MODE, SPY_STEPCNT, SPY_SCRATCH, SPY_ID, SPY_TRACE;
  - MODE bit index;
  - step FSM enum.
- One sub-module, `spy_trace_fifo`: depth 8, overwrite-on-full, with push, pop, dout and count. Instantiated only under the macro.

## Test plan
- Write 16'h1234 to address 4, then read address 4 → `spy_out`=16'h1234 one cycle after `dbread`; 0 after `dbread` drops. Read address 5 → 16'hCADD. Read address 9 → 0.
- Hold `dbwrite` high 5 cycles with `spy_in` changing → exactly one commit, using the value at the rise edge.
- Write MODE=1, then STEPCNT=3, answering each `step` with `fetch` 4 cycles later → exactly 3 `step` pulses; STEPCNT reads 2, 1, 0; `step_busy` falls after the third `fetch`.
- Write STEPCNT=5 with halt=0 → no `step` pulse, STEPCNT reads 0. Then set halt=1, write STEPCNT=5, and clear halt during the second WAIT → count 0, FSM IDLE, no further pulses.
- Assert `dbread` and `dbwrite` together on address 4 → SCRATCH updated, `spy_out`=0. Assert reset during WAIT → all outputs 0 asynchronously.
- With the macro, 10 fetches at PCs 1–10 → 8 reads of address 6 return 16'h8003 through 16'h800A; the 9th read returns 0.
